// File: rtl/oam_dma_pkg.sv
// -----------------------------------------------------------------------------
// oam_dma_pkg
// Shared types and constants for the OAM DMA engine.
//   oam_dma_state_t   : engine state (IDLE / START / XFER)
//   OAM_DMA_BYTES     : bytes copied per transfer (one full OAM image)
//   OAM_DMA_ECHO_BASE : first source page that is folded down onto work RAM
// -----------------------------------------------------------------------------
package oam_dma_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      XFER  = 2'd2
   } oam_dma_state_t;

   localparam int         OAM_DMA_BYTES     = 160;
   localparam logic [7:0] OAM_DMA_ECHO_BASE = 8'hE0;
   localparam logic [7:0] OAM_DMA_LAST_IDX  = 8'(OAM_DMA_BYTES - 1);

endpackage

// File: rtl/oam_dma_if.sv
// -----------------------------------------------------------------------------
// oam_dma_if
// Bundles the CPU register port, the source-bus read port and the OAM write
// port of the DMA engine.
//   master : the DMA engine itself
//   slave  : CPU / source memory / PPU side
//
// Handshake semantics: there is no valid/ready pair on this bus. reg_write is a
// single-cycle strobe sampled on posedge clk and is always accepted (it
// restarts any transfer in flight). oam_write is a single-cycle strobe that the
// OAM must accept unconditionally. dma_d_in is the synchronous read data for
// the dma_src_addr presented in the previous cycle.
// -----------------------------------------------------------------------------
interface oam_dma_if;

   logic        reg_write;
   logic [7:0]  reg_d_wr;
   logic [7:0]  reg_d_rd;
   logic        dma_active;
   logic [15:0] dma_src_addr;
   logic [7:0]  dma_d_in;
   logic [7:0]  oam_addr;
   logic [7:0]  oam_d_wr;
   logic        oam_write;

   modport master (
      input  reg_write, reg_d_wr, dma_d_in,
      output reg_d_rd, dma_active, dma_src_addr, oam_addr, oam_d_wr, oam_write
   );

   modport slave (
      output reg_write, reg_d_wr, dma_d_in,
      input  reg_d_rd, dma_active, dma_src_addr, oam_addr, oam_d_wr, oam_write
   );

endinterface

// File: rtl/oam_dma.sv
// -----------------------------------------------------------------------------
// oam_dma
// OAM DMA engine. A CPU write to FF46 starts a 160-byte copy from
// {page, 8'h00} into OAM, one byte every CYCLES_PER_BYTE clocks, after a
// START delay of CYCLES_PER_BYTE clocks.
//
// Parameters
//   CYCLES_PER_BYTE : clocks per transferred byte, legal range 2..16
// Ports
//   clk       : system clock, posedge
//   rst       : asynchronous active-high reset
//   bus       : oam_dma_if.master (register, source-read and OAM-write ports)
//   dbg_state : current engine state, for observation only
// -----------------------------------------------------------------------------
module oam_dma
   import oam_dma_pkg::*;
#(
   parameter int CYCLES_PER_BYTE = 4
) (
   input  logic           clk,
   input  logic           rst,
   oam_dma_if.master      bus,
   output oam_dma_state_t dbg_state
);

   // Last value of both the START counter and the per-byte slot counter.
   localparam logic [3:0] SUB_LAST = 4'(CYCLES_PER_BYTE - 1);

   oam_dma_state_t state_q, state_d;
   logic [7:0]     page_q, page_d;
   logic [7:0]     idx_q, idx_d;
   logic [3:0]     sub_q, sub_d;
   logic [3:0]     start_ctr_q, start_ctr_d;

   logic [7:0]     eff_page;
   logic           dma_active;
   logic [15:0]    dma_src_addr;
   logic [7:0]     oam_addr;
   logic           oam_write;

   // ---------------------------------------------------------------- state reg
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         page_q      <= 8'hFF;
         idx_q       <= 8'h00;
         sub_q       <= 4'h0;
         start_ctr_q <= 4'h0;
      end else begin
         state_q     <= state_d;
         page_q      <= page_d;
         idx_q       <= idx_d;
         sub_q       <= sub_d;
         start_ctr_q <= start_ctr_d;
      end
   end

   // --------------------------------------------------------------- next state
   always_comb begin
      state_d     = state_q;
      page_d      = page_q;
      idx_d       = idx_q;
      sub_d       = sub_q;
      start_ctr_d = start_ctr_q;

      if (bus.reg_write) begin
         // A register write restarts from any state, including the final slot
         // of a running transfer, so it takes priority over the FSM below.
         page_d      = bus.reg_d_wr;
         idx_d       = 8'h00;
         sub_d       = 4'h0;
         start_ctr_d = 4'h0;
         state_d     = START;
      end else begin
         case (state_q)
            IDLE: begin
            end

            START: begin
               if (start_ctr_q == SUB_LAST) begin
                  state_d     = XFER;
                  start_ctr_d = 4'h0;
                  idx_d       = 8'h00;
                  sub_d       = 4'h0;
               end else begin
                  start_ctr_d = start_ctr_q + 4'h1;
               end
            end

            XFER: begin
               if (sub_q == SUB_LAST) begin
                  sub_d = 4'h0;
                  if (idx_q == OAM_DMA_LAST_IDX) begin
                     state_d = IDLE;
                     idx_d   = 8'h00;
                  end else begin
                     idx_d = idx_q + 8'h01;
                  end
               end else begin
                  sub_d = sub_q + 4'h1;
               end
            end

            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   // Echo WRAM pages E0-FF alias C0-DF; the subtraction cannot wrap here.
   assign eff_page = (page_q >= OAM_DMA_ECHO_BASE) ? (page_q - 8'h20) : page_q;

   // ------------------------------------------------------------------ outputs
   // Decoded only from registered state so reg_write in the same cycle cannot
   // disturb a write that is already on the bus.
   always_comb begin
      dma_active   = 1'b0;
      dma_src_addr = 16'h0000;
      oam_write    = 1'b0;
      oam_addr     = 8'h00;
      if (state_q == XFER) begin
         dma_active = 1'b1;
         if (sub_q == 4'h0) begin
            dma_src_addr = {eff_page, idx_q};
         end
         // Read data for the sub==0 address arrives in this slot.
         if (sub_q == 4'h1) begin
            oam_write = 1'b1;
            oam_addr  = idx_q;
         end
      end
   end

   assign bus.dma_active   = dma_active;
   assign bus.dma_src_addr = dma_src_addr;
   assign bus.oam_write    = oam_write;
   assign bus.oam_addr     = oam_addr;
   assign bus.oam_d_wr     = bus.dma_d_in;
   assign bus.reg_d_rd     = page_q;
   assign dbg_state        = state_q;

endmodule
